// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - Iterative multiply/divide sequencer owning the HI/LO register pair
// One bit per cycle shift-add multiply / restoring divide on operand magnitudes, sign fix in FIX.
module muldiv_ctrl #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mf_req,
  input  logic        mf_sel,
  input  logic        mt_we,
  input  logic [31:0] mt_data,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_FIX = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   acc_q, acc_d;
  logic [31:0]   opnd_q, opnd_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d;
  logic          div0_q, div0_d, done_q, done_d;

  logic          accept;
  logic [31:0]   a_mag, b_mag;
  logic [32:0]   rem_sh, trial, sum;
  logic [63:0]   prod_fix;
  logic [31:0]   quo_fix, rem_fix;

  assign accept = (state_q == S_IDLE) & ~flush & start;
  assign a_mag  = (op[0] & a[31]) ? -a : a;
  assign b_mag  = (op[0] & b[31]) ? -b : b;

  // acc holds {HI,LO} partial product for multiply, {rem,quo} for divide
  assign rem_sh   = acc_q[63:31];
  assign trial    = rem_sh - {1'b0, opnd_q};
  assign sum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign prod_fix = neg_q ? -acc_q : acc_q;
  // A zero divisor leaves rem=|a|, so the remainder sign fix restores raw a; only LO is forced
  assign quo_fix  = div0_q ? 32'hFFFF_FFFF : (neg_q ? -acc_q[31:0] : acc_q[31:0]);
  assign rem_fix  = rneg_q ? -acc_q[63:32] : acc_q[63:32];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_BUSY;
      S_BUSY:  if (flush) state_d = S_IDLE;
               else if (cnt_q == LAST) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != S_IDLE);
    stall = busy & (start | mf_req | mt_we);
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    done_d   = 1'b0;
    if (accept) begin
      is_div_d = op[1];
      neg_d    = op[0] & (a[31] ^ b[31]);
      rneg_d   = op[0] & a[31];
      div0_d   = op[1] & (b == 32'd0);
      opnd_d   = op[1] ? b_mag : a_mag;
      acc_d    = {32'd0, op[1] ? a_mag : b_mag};
      cnt_d    = '0;
    end else if (state_q == S_IDLE && !flush && mt_we) begin
      if (mf_sel) hi_d = mt_data;
      else        lo_d = mt_data;
    end else if (state_q == S_BUSY && !flush) begin
      cnt_d = cnt_q + 1'b1;
      if (is_div_q) begin
        if (!trial[32]) acc_d = {trial[31:0], acc_q[30:0], 1'b1};
        else            acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
      end else begin
        acc_d = {sum, acc_q[31:1]};
      end
    end else if (state_q == S_FIX && !flush) begin
      done_d = 1'b1;
      if (is_div_q) begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end else begin
        hi_d = prod_fix[63:32];
        lo_d = prod_fix[31:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
    end
  end

  assign done       = done_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign hilo_rdata = mf_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - Self-checking bench for muldiv_ctrl
// Reference model uses plain 64-bit arithmetic and a cycle countdown from start acceptance.
module tb_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        mf_req = 1'b0, mf_sel = 1'b0, mt_we = 1'b0;
  logic [31:0] mt_data = 32'd0;
  logic        flush = 1'b0;
  logic        stall, busy, done;
  logic [31:0] hilo_rdata, hi, lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [63:0] m_pend = 64'd0;
  logic        m_done = 1'b0;
  int          m_left = 0;

  muldiv_ctrl #(.ITER(32)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .op(op), .a(a), .b(b),
    .mf_req(mf_req), .mf_sel(mf_sel), .mt_we(mt_we), .mt_data(mt_data), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .hilo_rdata(hilo_rdata), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Returns {HI,LO} for the operation
  function automatic logic [63:0] ref_result(input logic [1:0] f_op, input logic [31:0] fa,
                                             input logic [31:0] fb);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(fa));
    sb = longint'($signed(fb));
    ua = {32'd0, fa};
    ub = {32'd0, fb};
    case (f_op)
      2'd0: ref_result = ua * ub;
      2'd1: ref_result = sa * sb;
      default: begin
        if (fb == 32'd0) ref_result = {fa, 32'hFFFF_FFFF};
        else if (f_op == 2'd2) ref_result = {32'(ua % ub), 32'(ua / ub)};
        else begin
          q = sa / sb;
          r = sa % sb;
          ref_result = {r[31:0], q[31:0]};
        end
      end
    endcase
  endfunction

  // Compare and model update on the falling edge; inputs are stable there
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_b) begin
        m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_done = 1'b0;
      end
      chk("busy", 64'(busy), 64'(m_left > 0));
      chk("done", 64'(done), 64'(m_done));
      chk("stall", 64'(stall), 64'((m_left > 0) && (start || mf_req || mt_we)));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
      chk("hilo_rdata", 64'(hilo_rdata), 64'(mf_sel ? m_hi : m_lo));
      if (reset_b) begin
        m_done = 1'b0;
        if (m_left == 0) begin
          if (!flush) begin
            if (start) begin
              m_pend = ref_result(op, a, b);
              m_left = 33;
            end else if (mt_we) begin
              if (mf_sel) m_hi = mt_data;
              else        m_lo = mt_data;
            end
          end
        end else if (flush) begin
          m_left = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            {m_hi, m_lo} = m_pend;
            m_done = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
    chk("lat_busy_c1", 64'(busy), 64'd1);
    repeat (32) tick();
    chk("lat_busy_c33", 64'(busy), 64'd1);
    chk("lat_done_c33", 64'(done), 64'd0);
    tick();
    chk("lat_done_c34", 64'(done), 64'd1);
    chk("lat_busy_c34", 64'(busy), 64'd0);
    chk("res_hi", 64'(hi), 64'(exp_hi));
    chk("res_lo", 64'(lo), 64'(exp_lo));
    tick();
    chk("done_pulse_c35", 64'(done), 64'd0);
  endtask

  function automatic logic [31:0] rnd_operand;
    case ($urandom_range(0, 6))
      0:       rnd_operand = 32'd0;
      1:       rnd_operand = 32'hFFFF_FFFF;
      2:       rnd_operand = 32'h8000_0000;
      3:       rnd_operand = $urandom_range(0, 20);
      default: rnd_operand = $urandom;
    endcase
  endfunction

  initial begin
    chk("ref_multu", ref_result(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    chk("ref_mult", ref_result(2'd1, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
    chk("ref_div", ref_result(2'd3, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("ref_divu0", ref_result(2'd2, 32'd100, 32'd0), 64'h0000_0064_FFFF_FFFF);
    chk("ref_divovf", ref_result(2'd3, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    reset_b = 1'b1;
    tick();

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(2'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(2'd2, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // MULTU 6x7 with MFLO waiting from cycle 2
    start = 1'b1; op = 2'd0; a = 32'd6; b = 32'd7;
    tick();
    start = 1'b0;
    tick();
    mf_req = 1'b1; mf_sel = 1'b0;
    for (int c = 2; c <= 33; c++) begin
      #1;
      chk($sformatf("mf_stall_c%0d", c), 64'(stall), 64'd1);
      tick();
    end
    #1;
    chk("mf_stall_c34", 64'(stall), 64'd0);
    chk("mf_rdata_c34", 64'(hilo_rdata), 64'd42);
    mf_req = 1'b0;
    tick();

    // Flush in cycle 10, then MTHI
    start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd5;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi), 64'd0);
    chk("flush_lo", 64'(lo), 64'd42);
    for (int c = 0; c < 30; c++) begin
      tick();
      chk("flush_nodone", 64'(done), 64'd0);
    end
    mt_we = 1'b1; mf_sel = 1'b1; mt_data = 32'hDEAD_BEEF;
    tick();
    mt_we = 1'b0; mf_sel = 1'b0;
    chk("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
    chk("mthi_lo", 64'(lo), 64'd42);

    // Asynchronous reset in cycle 20 of a DIV
    start = 1'b1; op = 2'd3; a = 32'hFFFF_FF9C; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (19) tick();
    #1;
    reset_b = 1'b0;
    #1;
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    tick();
    tick();
    reset_b = 1'b1;
    tick();
    run_op(2'd0, 32'd2, 32'd3, 32'd0, 32'd6);

    // Randomized traffic checked every cycle by the model
    for (int i = 0; i < 2500; i++) begin
      start   = ($urandom_range(0, 2) != 0);
      op      = 2'($urandom_range(0, 3));
      a       = rnd_operand();
      b       = rnd_operand();
      mf_req  = ($urandom_range(0, 2) == 0);
      mf_sel  = 1'($urandom_range(0, 1));
      mt_we   = ($urandom_range(0, 3) == 0);
      mt_data = $urandom;
      flush   = ($urandom_range(0, 39) == 0);
      tick();
    end
    start = 1'b0; mf_req = 1'b0; mt_we = 1'b0; flush = 1'b0;
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer that owns the HI/LO register pair for the pipelined CPU. It sits beside the EX-stage ALU. It takes forwarded operands for MULT/MULTU/DIV/DIVU and runs a 1-bit-per-cycle shift-add or restoring-divide engine. It serialises access to HI/LO for MFHI/MFLO/MTHI/MTLO, and it stalls the pipeline while the shared engine is busy.

## Interface
Parameters:
- ITER, 32, number of iteration cycles (equal to the operand width; fixed at 32).

Ports:
- clk  input  1  clock, rising edge.
- reset_b  input  1  asynchronous, active-low reset.
- start  input  1  EX holds a mul/div instruction this cycle.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  32  forwarded Rs operand (multiplicand / dividend).
- b  input  32  forwarded Rt operand (multiplier / divisor).
- mf_req  input  1  EX holds MFHI/MFLO.
- mf_sel  input  1  0 selects LO, 1 selects HI (used by both mf and mt).
- mt_we  input  1  EX holds MTHI/MTLO.
- mt_data  input  32  data for MTHI/MTLO.
- flush  input  1  kill the in-flight operation (exception/redirect).
- stall  output  1  freeze IF/ID/EX; combinational.
- busy  output  1  engine not IDLE.
- done  output  1  one-cycle pulse: new HI/LO result visible.
- hilo_rdata  output  32  mf_sel ? HI : LO; combinational.
- hi, lo  output  32 each  current HI/LO registers.

## Operation
- FSM states: IDLE, BUSY, FIX.
  - IDLE→BUSY on start when flush=0.
  - BUSY→FIX when the 5-bit iteration counter reaches 31.
  - FIX→IDLE unconditionally.
  - BUSY or FIX→IDLE on flush.
- Start capture:
  - Latch op.
  - Store operand magnitudes: signed ops use |a| and |b|; unsigned ops use raw values.
  - Record the result signs: product/quotient sign = a[31]^b[31], remainder sign = a[31]. Both are forced to 0 for unsigned ops.
  - Clear the counter.
- Multiply: 64-bit accumulator; each BUSY cycle adds the multiplicand when the multiplier LSB is 1, then shifts right 1.
- Divide: restoring algorithm; each BUSY cycle shifts {rem,quo} left 1, trial-subtracts the divisor, and sets the quotient bit if the result is non-negative.
- FIX: negate the 64-bit product, or the quotient and remainder independently, per the recorded signs. Write HI and LO at the end of FIX.
  - Multiply result: {HI,LO} = 64-bit product.
  - Divide result: LO = quotient, HI = remainder.
- Divide by zero: LO=32'hFFFFFFFF, HI=a (raw operand, no sign fix), for both DIV and DIVU.
- DIV 0x80000000 / -1: LO=0x80000000, HI=0. This falls out of the magnitude method and needs no special case.
- MTHI/MTLO: in IDLE with mt_we=1 and start=0, the selected register takes mt_data at the edge.
- Input priority in IDLE: flush > start > mt_we. flush in IDLE ignores start and mt_we.
- stall = (state≠IDLE) & (start | mf_req | mt_we).
  - The pipeline holds the instruction in EX; a held start is accepted on the first IDLE cycle.
- flush: the partial result is discarded, HI/LO are unchanged and no done pulse is produced.

## Timing
- Reset values (asynchronous, while reset_b=0): state IDLE, HI=LO=0, counter=0, busy=0, done=0, stall=0.
  - Reset mid-operation aborts the operation and also zeroes HI/LO.
- Latency, with start sampled at the edge ending cycle 0:
  - cycles 1-32: BUSY.
  - cycle 33: FIX.
  - cycle 34: IDLE, done=1, new HI/LO visible on hi/lo/hilo_rdata.
- busy=1 in cycles 1-33.
- mf_req issued in cycles 1-33 gets stall=1 through cycle 33 and reads the new value in cycle 34.
- Back-to-back start: a start held from cycle 1 is accepted at the edge ending cycle 34; its BUSY runs cycles 35-66.
- flush asserted in cycle k (1≤k≤33): IDLE from cycle k+1, done stays 0.
- done is registered and high for exactly one cycle.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → cycle 34: HI=0xFFFFFFFE, LO=0x00000001, done=1 for one cycle; busy=1 in cycles 1-33.
- MULT a=-3, b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 → LO=0xFFFFFFFF, HI=100.
- DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MULTU 6×7 started, mf_req with mf_sel=0 from cycle 2 → stall=1 in cycles 2-33; cycle 34: stall=0, hilo_rdata=42.
- MULTU started, flush in cycle 10 → busy=0 from cycle 11, HI/LO keep prior values, no done. Then MTHI 0xDEADBEEF in IDLE → hi=0xDEADBEEF next cycle.
- reset_b pulsed low in cycle 20 of a DIV → outputs immediately at reset values, HI=LO=0. After release, a new MULTU 2×3 gives LO=6 after 34 cycles.
